// File: rtl/imem_loader_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : imem_loader_pkg
//  Description : Shared types and constants for the instruction-memory
//                program loader (state encoding, frame geometry).
//  Revision    : 1.0 - initial release
// ============================================================================
package imem_loader_pkg;

    // Bytes packed into one instruction word (little-endian)
    localparam int BYTES_PER_WORD = 4;

    // Frame header length: word-count low byte then high byte
    localparam int HDR_BYTES = 2;

    // Loader state encoding
    typedef enum logic [2:0] {
        HDR0 = 3'd0,
        HDR1 = 3'd1,
        DATA = 3'd2,
        CSUM = 3'd3,
        DONE = 3'd4,
        ERR  = 3'd5
    } state_t;

endpackage : imem_loader_pkg
`default_nettype wire

// File: rtl/imem_loader_word_packer.sv
`default_nettype none
// ============================================================================
//  Module      : word_packer
//  Description : Packs a qualified byte stream into 32-bit little-endian
//                words. Flags the byte that completes a word and emits a
//                registered one-cycle word_valid pulse with the finished word.
//  Revision    : 1.0 - initial release
// ============================================================================
module word_packer
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_clear,
    input  logic        i_valid,
    input  logic [7:0]  i_byte,
    output logic        o_last,
    output logic [31:0] o_word,
    output logic        o_word_valid
);

    localparam int c_CNT_W = $clog2(BYTES_PER_WORD);

    logic [c_CNT_W-1:0] r_cnt;
    logic [31:0]        r_shift;
    logic [31:0]        r_word;
    logic               r_word_valid;
    logic [31:0]        w_shift_next;

    // New bytes enter at the top so the first byte ends up in [7:0]
    assign w_shift_next = {i_byte, r_shift[31:8]};
    assign o_last       = i_valid && (r_cnt == c_CNT_W'(BYTES_PER_WORD - 1));
    assign o_word       = r_word;
    assign o_word_valid = r_word_valid;

    // Byte counter, shift register and completed-word output register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt        <= '0;
            r_shift      <= '0;
            r_word       <= '0;
            r_word_valid <= 1'b0;
        end else begin
            r_word_valid <= 1'b0;
            if (i_clear) begin
                r_cnt   <= '0;
                r_shift <= '0;
            end else if (i_valid) begin
                r_cnt   <= r_cnt + 1'b1;
                r_shift <= w_shift_next;
                if (o_last) begin
                    r_word       <= w_shift_next;
                    r_word_valid <= 1'b1;
                end
            end
        end
    end

endmodule : word_packer
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
//  Module      : imem_loader
//  Description : Framed byte-stream program loader. Parses {NL, NH, data,
//                CS}, writes packed words to consecutive instruction-memory
//                addresses in the selected bank, verifies the XOR checksum
//                and holds the CPU in reset until a load succeeds.
//  Revision    : 1.0 - initial release
// ============================================================================
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fileid,
    input  logic              start,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              imem_we,
    output logic [ADDR_W:0]   imem_waddr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_rst,
    output logic              done,
    output logic              error
);

    state_t              r_state;
    state_t              w_state_next;

    logic                r_bank;
    logic [7:0]          r_nl;
    logic [15:0]         r_left;
    logic [ADDR_W-1:0]   r_index;
    logic [7:0]          r_xor;
    logic [ADDR_W:0]     r_waddr;

    logic                w_accept;
    logic                w_restart;
    logic [15:0]         w_n;
    logic                w_oversize;
    logic                w_pack_valid;
    logic                w_last;
    logic                w_last_word;

    assign w_accept     = in_valid && in_ready;
    assign w_restart    = start && ((r_state == DONE) || (r_state == ERR));
    assign w_n          = {in_data, r_nl};
    // Capacity is 2^ADDR_W words, so compare in 17 bits to cover ADDR_W=16
    assign w_oversize   = {1'b0, w_n} > (17'd1 << ADDR_W);
    assign w_pack_valid = w_accept && (r_state == DATA);
    assign w_last_word  = (r_left == 16'd1);

    word_packer u_packer (
        .clk          (clk),
        .rst          (rst),
        .i_clear      (w_restart),
        .i_valid      (w_pack_valid),
        .i_byte       (in_data),
        .o_last       (w_last),
        .o_word       (imem_wdata),
        .o_word_valid (imem_we)
    );

    assign imem_waddr = r_waddr;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= HDR0;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: header parse, data until last word, checksum verdict
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            HDR0: if (w_accept) w_state_next = HDR1;
            HDR1: begin
                if (w_accept) begin
                    if (w_oversize)          w_state_next = ERR;
                    else if (w_n == 16'd0)   w_state_next = CSUM;
                    else                     w_state_next = DATA;
                end
            end
            DATA: if (w_accept && w_last && w_last_word) w_state_next = CSUM;
            CSUM: begin
                if (w_accept) begin
                    w_state_next = (in_data == r_xor) ? DONE : ERR;
                end
            end
            DONE: if (start) w_state_next = HDR0;
            ERR:  if (start) w_state_next = HDR0;
            default: w_state_next = HDR0;
        endcase
    end

    // Status outputs decoded from state; forced to reset values while rst is high
    always_comb begin
        in_ready = 1'b0;
        cpu_rst  = 1'b1;
        done     = 1'b0;
        error    = 1'b0;
        if (!rst) begin
            case (r_state)
                HDR0, HDR1, DATA, CSUM: in_ready = 1'b1;
                DONE: begin
                    cpu_rst = 1'b0;
                    done    = 1'b1;
                end
                ERR:  error = 1'b1;
                default: in_ready = 1'b0;
            endcase
        end
    end

    // Datapath: bank, word count, index, checksum and write address
    always_ff @(posedge clk) begin
        if (rst) begin
            r_bank  <= 1'b0;
            r_nl    <= '0;
            r_left  <= '0;
            r_index <= '0;
            r_xor   <= '0;
            r_waddr <= '0;
        end else if (w_restart) begin
            r_left  <= '0;
            r_index <= '0;
            r_xor   <= '0;
        end else if (w_accept) begin
            case (r_state)
                HDR0: begin
                    r_bank <= fileid;
                    r_nl   <= in_data;
                end
                HDR1: r_left <= w_n;
                DATA: begin
                    r_xor <= r_xor ^ in_data;
                    if (w_last) begin
                        r_waddr <= {r_bank, r_index};
                        r_left  <= r_left - 1'b1;
                        // Holding on the final word keeps a full bank from wrapping
                        if (!w_last_word) begin
                            r_index <= r_index + 1'b1;
                        end
                    end
                end
                default: r_nl <= r_nl;
            endcase
        end
    end

endmodule : imem_loader
`default_nettype wire
